// File: rtl/adc_seq_sampler.sv
// Multi-channel CONVST/SPI sequencer for an LTC2308-style ADC with a channel-tagged
// first-word-fall-through result FIFO.
module adc_seq_sampler #(
  parameter int NUM_CH      = 8,
  parameter int DATA_W      = 12,
  parameter int CFG_W       = 6,
  parameter int SCLK_DIV    = 2,
  parameter int CONV_CYCLES = 80,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic                          clk_clk,
  input  logic                          reset_reset_n,
  input  logic                          enable,
  input  logic                          continuous,
  input  logic                          trig,
  input  logic [NUM_CH-1:0]             ch_mask,
  output logic                          adc_cs,
  output logic                          adc_sclk,
  output logic                          adc_din,
  input  logic                          adc_dout,
  output logic                          smp_valid,
  input  logic                          smp_ready,
  output logic [DATA_W-1:0]             smp_data,
  output logic [2:0]                    smp_ch,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  input  logic                          overflow_clr,
  output logic                          busy
);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(CONV_CYCLES + SCLK_DIV + 1);
  localparam int BIT_W = $clog2(DATA_W);
  localparam int ENT_W = DATA_W + 3;

  typedef enum logic [2:0] {S_IDLE, S_CONV, S_GAP, S_SHIFT, S_TAIL} state_t;

  function automatic logic [2:0] f_lowest(input logic [NUM_CH-1:0] m);
    f_lowest = 3'd0;
    for (int i = NUM_CH - 1; i >= 0; i--)
      if (m[i]) f_lowest = 3'(i);
  endfunction

  function automatic logic f_has_above(input logic [NUM_CH-1:0] m, input logic [2:0] cur);
    f_has_above = 1'b0;
    for (int i = 0; i < NUM_CH; i++)
      if (m[i] && (i > int'(cur))) f_has_above = 1'b1;
  endfunction

  function automatic logic [2:0] f_next(input logic [NUM_CH-1:0] m, input logic [2:0] cur);
    f_next = f_lowest(m);
    for (int i = NUM_CH - 1; i >= 0; i--)
      if (m[i] && (i > int'(cur))) f_next = 3'(i);
  endfunction

  state_t              r_state;
  logic                r_cs, r_sclk, r_din;
  logic                r_primed, r_final, r_cont;
  logic [CNT_W-1:0]    r_cnt;
  logic [BIT_W-1:0]    r_bit;
  logic [2:0]          r_ch, r_prev_ch;
  logic [CFG_W-1:0]    r_cfg_sh;
  logic [DATA_W-1:0]   r_shift;
  logic [CFG_W-1:0]    w_cfg;
  logic                w_start;

  // Single-ended, unipolar, no sleep: {S/D, O/S, S1, S0, UNI, SLP}
  assign w_cfg   = CFG_W'({1'b1, r_ch[0], r_ch[2], r_ch[1], 1'b1, 1'b0});
  assign w_start = reset_reset_n && (r_state == S_IDLE) && (|ch_mask) && enable
                   && (continuous || trig);

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      r_state  <= S_IDLE;
      r_cs     <= 1'b0;
      r_sclk   <= 1'b0;
      r_din    <= 1'b0;
      r_primed <= 1'b0;
      r_final  <= 1'b0;
      r_cont   <= 1'b0;
      r_cnt    <= '0;
      r_bit    <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_start) begin
          r_state  <= S_CONV;
          r_cs     <= 1'b1;
          r_cnt    <= '0;
          r_ch     <= f_lowest(ch_mask);
          r_cont   <= continuous;
          r_final  <= 1'b0;
          r_primed <= 1'b0;
        end
        S_CONV: if (r_cnt == CNT_W'(CONV_CYCLES - 1)) begin
          r_state  <= S_GAP;
          r_cs     <= 1'b0;
          r_cnt    <= '0;
          r_din    <= w_cfg[CFG_W-1];
          r_cfg_sh <= {w_cfg[CFG_W-2:0], 1'b0};
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
        S_GAP: begin
          r_state <= S_SHIFT;
          r_bit   <= '0;
          r_cnt   <= '0;
        end
        // SCLK low phase first; sample on the rise, advance config on the fall
        S_SHIFT: if (r_cnt == CNT_W'(SCLK_DIV - 1)) begin
          r_cnt <= '0;
          if (!r_sclk) begin
            r_sclk  <= 1'b1;
            r_shift <= {r_shift[DATA_W-2:0], adc_dout};
          end else begin
            r_sclk   <= 1'b0;
            r_din    <= r_cfg_sh[CFG_W-1];
            r_cfg_sh <= {r_cfg_sh[CFG_W-2:0], 1'b0};
            if (r_bit == BIT_W'(DATA_W - 1)) r_state <= S_TAIL;
            else                             r_bit   <= r_bit + 1'b1;
          end
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
        S_TAIL: begin
          r_prev_ch <= r_ch;
          r_ch      <= f_next(ch_mask, r_ch);
          r_primed  <= 1'b1;
          if (!enable || (ch_mask == '0) || (r_cont && !continuous) || (!r_cont && r_final)) begin
            r_state  <= S_IDLE;
            r_primed <= 1'b0;
          end else begin
            r_state <= S_CONV;
            r_cs    <= 1'b1;
            r_cnt   <= '0;
            if (!f_has_above(ch_mask, r_ch)) r_final <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign adc_cs   = r_cs;
  assign adc_sclk = r_sclk;
  assign adc_din  = r_din;
  assign busy     = (r_state != S_IDLE) || w_start;

  // Result FIFO: data written in TAIL belongs to the channel configured one frame earlier
  logic [ENT_W-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]    r_wr, r_rd;
  logic [AW:0]      r_level;
  logic             r_ovf;
  logic             w_push, w_pop, w_full, w_push_ok;
  logic [ENT_W-1:0] w_head;

  assign w_push    = reset_reset_n && (r_state == S_TAIL) && r_primed;
  assign w_full    = (r_level == (AW + 1)'(FIFO_DEPTH));
  assign smp_valid = (r_level != '0);
  assign w_pop     = smp_valid && smp_ready;
  assign w_push_ok = w_push && (!w_full || w_pop);
  assign w_head    = r_mem[r_rd];

  always_ff @(posedge clk_clk) begin
    if (w_push_ok) r_mem[r_wr] <= {r_prev_ch, r_shift};
  end

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_level <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_push_ok) r_wr <= r_wr + 1'b1;
      if (w_pop)     r_rd <= r_rd + 1'b1;
      case ({w_push_ok, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
      if (w_push && w_full && !w_pop) r_ovf <= 1'b1;
      else if (overflow_clr)          r_ovf <= 1'b0;
    end
  end

  assign smp_data   = smp_valid ? w_head[DATA_W-1:0] : '0;
  assign smp_ch     = smp_valid ? w_head[ENT_W-1:DATA_W] : 3'd0;
  assign fifo_level = r_level;
  assign overflow   = r_ovf;

endmodule

// File: tb/tb_adc_seq_sampler.sv
// Scoreboard bench for adc_seq_sampler: an ADC pin model returns 12'hA00+channel for the
// channel configured one frame earlier; a monitor pops expected results on each handshake.
module tb_adc_seq_sampler;
  logic        clk_clk = 1'b0;
  logic        reset_reset_n, enable, continuous, trig, smp_ready, overflow_clr;
  logic [7:0]  ch_mask;
  logic        adc_cs, adc_sclk, adc_din, adc_dout;
  logic        smp_valid, overflow, busy;
  logic [11:0] smp_data;
  logic [2:0]  smp_ch;
  logic [2:0]  fifo_level;

  adc_seq_sampler #(
    .NUM_CH(8), .DATA_W(12), .CFG_W(6), .SCLK_DIV(2), .CONV_CYCLES(80), .FIFO_DEPTH(4)
  ) dut (
    .clk_clk(clk_clk), .reset_reset_n(reset_reset_n), .enable(enable),
    .continuous(continuous), .trig(trig), .ch_mask(ch_mask),
    .adc_cs(adc_cs), .adc_sclk(adc_sclk), .adc_din(adc_din), .adc_dout(adc_dout),
    .smp_valid(smp_valid), .smp_ready(smp_ready), .smp_data(smp_data), .smp_ch(smp_ch),
    .fifo_level(fifo_level), .overflow(overflow), .overflow_clr(overflow_clr), .busy(busy)
  );

  always #5 clk_clk = ~clk_clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  logic [14:0] exp_q[$];
  logic [11:0] din_log[$];
  int          cs_log[$];
  int          rise_log[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_chk++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp_v);
    end
  endtask

  task automatic push_exp(input logic [2:0] ch);
    exp_q.push_back({ch, 12'hA00 + {9'd0, ch}});
  endtask

  task automatic wait_idle(input string nm, input int budget);
    int k = 0;
    while (busy && k < budget) begin
      @(posedge clk_clk); #1;
      k++;
    end
    chk(nm, {31'd0, busy}, 32'd0);
  endtask

  always @(posedge clk_clk) cyc <= cyc + 1;

  // ADC pin model, evaluated away from the active edge
  logic [11:0] out_sh = '0, din_sh = '0;
  logic [5:0]  cap = '0;
  int          rise_n = 0, cs_cnt = 0;
  logic        prev_cs = 1'b0, prev_sclk = 1'b0;
  initial adc_dout = 1'b0;

  always @(negedge clk_clk) begin
    if (adc_cs && !prev_cs) rise_log.push_back(cyc);
    if (adc_cs) cs_cnt++;
    if (!adc_cs && prev_cs) begin
      cs_log.push_back(cs_cnt);
      cs_cnt = 0;
      out_sh = 12'hA00 + {9'd0, cap[3], cap[2], cap[4]};
      rise_n = 0;
    end
    if (adc_sclk && !prev_sclk) begin
      din_sh = {din_sh[10:0], adc_din};
      if (rise_n < 6) cap = {cap[4:0], adc_din};
      rise_n++;
      if (rise_n == 12) din_log.push_back(din_sh);
    end
    if (!adc_sclk && prev_sclk) out_sh = {out_sh[10:0], 1'b0};
    adc_dout  = out_sh[11];
    prev_cs   = adc_cs;
    prev_sclk = adc_sclk;
  end

  // Scoreboard monitor
  always @(negedge clk_clk) begin
    logic [14:0] e;
    if (reset_reset_n && smp_valid && smp_ready) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_result: got ch%0d data %03h, none expected", smp_ch, smp_data);
      end else begin
        e = exp_q.pop_front();
        chk("result", {17'd0, smp_ch, smp_data}, {17'd0, e});
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_reset_n = 1'b0; enable = 1'b0; continuous = 1'b0; trig = 1'b0;
    smp_ready = 1'b1; overflow_clr = 1'b0; ch_mask = 8'h00;
    repeat (3) @(posedge clk_clk); #1;
    chk("rst_cs", {31'd0, adc_cs}, 0);
    chk("rst_sclk", {31'd0, adc_sclk}, 0);
    chk("rst_din", {31'd0, adc_din}, 0);
    chk("rst_valid", {31'd0, smp_valid}, 0);
    chk("rst_overflow", {31'd0, overflow}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_level", {29'd0, fifo_level}, 0);
    chk("rst_data", {20'd0, smp_data}, 0);
    chk("rst_ch", {29'd0, smp_ch}, 0);
    reset_reset_n = 1'b1;
    @(posedge clk_clk); #1;

    // Zero mask ignores trig
    enable = 1'b1; trig = 1'b1; #1;
    chk("mask0_busy", {31'd0, busy}, 0);
    @(posedge clk_clk); #1; trig = 1'b0;
    repeat (3) @(posedge clk_clk); #1;
    chk("mask0_idle", {31'd0, busy}, 0);

    // Continuous scan of ch0/ch2, four results
    ch_mask = 8'h05; rise_log.delete();
    push_exp(3'd0); push_exp(3'd2); push_exp(3'd0); push_exp(3'd2);
    continuous = 1'b1; #1;
    chk("busy_on_start", {31'd0, busy}, 1);
    repeat (590) @(posedge clk_clk); #1;
    continuous = 1'b0;
    wait_idle("cont_idle", 300);
    if (rise_log.size() < 2) chk("frame_len_seen", rise_log.size(), 2);
    else chk("frame_len", 32'(rise_log[1] - rise_log[0]), 130);
    repeat (5) @(posedge clk_clk); #1;
    chk("cont_drained", exp_q.size(), 0);

    // Single pass over ch0/ch7 with an ignored second trig
    ch_mask = 8'h81;
    push_exp(3'd0); push_exp(3'd7);
    trig = 1'b1; #1;
    chk("single_busy_start", {31'd0, busy}, 1);
    @(posedge clk_clk); #1; trig = 1'b0;
    repeat (200) @(posedge clk_clk); #1;
    chk("single_busy_mid", {31'd0, busy}, 1);
    trig = 1'b1;
    @(posedge clk_clk); #1; trig = 1'b0;
    wait_idle("single_idle", 400);
    repeat (5) @(posedge clk_clk); #1;
    chk("single_drained", exp_q.size(), 0);

    // Config bits and CONVST width for ch5
    ch_mask = 8'h20; din_log.delete(); cs_log.delete();
    push_exp(3'd5);
    trig = 1'b1;
    @(posedge clk_clk); #1; trig = 1'b0;
    wait_idle("ch5_idle", 400);
    repeat (5) @(posedge clk_clk); #1;
    if (din_log.size() < 2) chk("din_frames", din_log.size(), 2);
    else begin
      chk("din_ch5_f1", {20'd0, din_log[0]}, 32'hE80);
      chk("din_ch5_f2", {20'd0, din_log[1]}, 32'hE80);
    end
    if (cs_log.size() < 1) chk("cs_frames", cs_log.size(), 1);
    else chk("cs_width", cs_log[0], 80);
    chk("ch5_drained", exp_q.size(), 0);

    // Overflow with the consumer stalled
    smp_ready = 1'b0; ch_mask = 8'h0F;
    push_exp(3'd0); push_exp(3'd1); push_exp(3'd2); push_exp(3'd3);
    continuous = 1'b1;
    repeat (720) @(posedge clk_clk); #1;
    continuous = 1'b0;
    wait_idle("ovf_idle", 300);
    chk("ovf_level", {29'd0, fifo_level}, 4);
    chk("ovf_flag", {31'd0, overflow}, 1);
    chk("ovf_valid", {31'd0, smp_valid}, 1);
    overflow_clr = 1'b1;
    @(posedge clk_clk); #1; overflow_clr = 1'b0;
    chk("ovf_cleared", {31'd0, overflow}, 0);
    smp_ready = 1'b1;
    for (int k = 0; k < 20 && fifo_level != 0; k++) begin
      @(posedge clk_clk); #1;
    end
    chk("ovf_level_empty", {29'd0, fifo_level}, 0);
    chk("ovf_drained", exp_q.size(), 0);

    // Reset in the middle of SHIFT, then a fresh priming frame
    ch_mask = 8'h01; continuous = 1'b1;
    repeat (221) @(posedge clk_clk); #1;
    reset_reset_n = 1'b0;
    @(posedge clk_clk); #1;
    chk("midrst_cs", {31'd0, adc_cs}, 0);
    chk("midrst_sclk", {31'd0, adc_sclk}, 0);
    chk("midrst_din", {31'd0, adc_din}, 0);
    chk("midrst_level", {29'd0, fifo_level}, 0);
    chk("midrst_busy", {31'd0, busy}, 0);
    @(posedge clk_clk); #1;
    reset_reset_n = 1'b1;
    repeat (195) @(posedge clk_clk); #1;
    push_exp(3'd0);
    continuous = 1'b0;
    wait_idle("midrst_idle", 300);
    repeat (5) @(posedge clk_clk); #1;
    chk("midrst_drained", exp_q.size(), 0);

    // Mask change 0x01 -> 0x06 during the third frame
    ch_mask = 8'h01;
    push_exp(3'd0); push_exp(3'd0); push_exp(3'd0); push_exp(3'd1); push_exp(3'd2);
    continuous = 1'b1;
    repeat (320) @(posedge clk_clk); #1;
    ch_mask = 8'h06;
    repeat (390) @(posedge clk_clk); #1;
    continuous = 1'b0;
    wait_idle("mask_idle", 300);
    repeat (5) @(posedge clk_clk); #1;
    chk("mask_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
